// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the RISC-V test-end monitor (package riscv_test_pkg).
// The optional instret counter is enabled with RISCV_TEST_MONITOR_INSTRET_EN.
package riscv_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TOUT
    } mon_state_e;

    localparam int          PASS_CODE       = 1;
    localparam logic [31:0] DEFAULT_END_PC  = 32'h44;
    localparam int          DEFAULT_TIMEOUT = 5000;

    // True while the test program is still executing and counters advance.
    function automatic logic is_active(input mon_state_e s);
        return (s == ST_RUN) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Core-observation and verdict signals of the test monitor, bundled as an interface.
// RISCV_TEST_MONITOR_INSTRET_EN adds the instret_count signal.
interface riscv_test_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             clear;
    logic [XLEN-1:0]  pc;
    logic             pc_valid;
    logic [XLEN-1:0]  gp;
    logic             done;
    logic             passed;
    logic             timed_out;
    logic [XLEN-2:0]  fail_num;
    logic [CNT_W-1:0] cycle_count;
`ifdef RISCV_TEST_MONITOR_INSTRET_EN
    logic [CNT_W-1:0] instret_count;

    modport master (output start, clear, pc, pc_valid, gp,
                    input  done, passed, timed_out, fail_num, cycle_count, instret_count);
    modport slave  (input  start, clear, pc, pc_valid, gp,
                    output done, passed, timed_out, fail_num, cycle_count, instret_count);
`else
    modport master (output start, clear, pc, pc_valid, gp,
                    input  done, passed, timed_out, fail_num, cycle_count);
    modport slave  (input  start, clear, pc, pc_valid, gp,
                    output done, passed, timed_out, fail_num, cycle_count);
`endif
endinterface

// File: rtl/mon_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module mon_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/riscv_test_monitor.sv
// Watches the core PC for the test-end loop, waits SETTLE hits, then latches pass/fail/timeout from gp.
// Define RISCV_TEST_MONITOR_INSTRET_EN to add instret_count (valid PCs seen while running).
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] END_PC  = XLEN'(DEFAULT_END_PC),
    parameter int              SETTLE  = 4,
    parameter int              TIMEOUT = DEFAULT_TIMEOUT,
    parameter int              CNT_W   = 32
) (
    input logic                 clk,
    input logic                 rst,
    riscv_test_monitor_if.slave mon
);

    mon_state_e       r_state, w_state_next;
    logic [7:0]       r_settle, w_settle_next;
    logic [XLEN-2:0]  r_fail_num, w_fail_num_next;
    logic             r_done, r_passed, r_timed_out;
    logic [CNT_W-1:0] w_cycle_count;
    logic             w_pc_hit, w_at_limit, w_sample, w_cnt_clear, w_cnt_en;

    assign w_pc_hit   = mon.pc_valid && (mon.pc == END_PC);
    assign w_at_limit = (w_cycle_count == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next    = r_state;
        w_settle_next   = r_settle;
        w_fail_num_next = r_fail_num;
        w_sample        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mon.start) begin
                    w_state_next  = ST_RUN;
                    w_settle_next = '0;
                end
            end
            ST_RUN: begin
                if (w_pc_hit) begin
                    if (SETTLE == 1) begin
                        w_sample = 1'b1;
                    end else begin
                        w_state_next  = ST_SETTLE;
                        w_settle_next = 8'd1;
                    end
                end
            end
            ST_SETTLE: begin
                // Bubbles (pc_valid low) neither advance nor break the settle run.
                if (w_pc_hit) begin
                    if (r_settle == 8'(SETTLE - 1)) begin
                        w_sample = 1'b1;
                    end else begin
                        w_settle_next = r_settle + 8'd1;
                    end
                end else if (mon.pc_valid) begin
                    w_state_next  = ST_RUN;
                    w_settle_next = '0;
                end
            end
            default: ;
        endcase

        // A verdict sampled in the limit cycle beats the timeout.
        if (w_sample) begin
            w_settle_next = '0;
            if (mon.gp == XLEN'(PASS_CODE)) begin
                w_state_next    = ST_PASS;
                w_fail_num_next = '0;
            end else begin
                w_state_next    = ST_FAIL;
                w_fail_num_next = mon.gp[XLEN-1:1];
            end
        end else if (is_active(r_state) && w_at_limit) begin
            w_state_next  = ST_TOUT;
            w_settle_next = '0;
        end

        if (mon.clear) begin
            w_state_next    = ST_IDLE;
            w_settle_next   = '0;
            w_fail_num_next = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_settle    <= '0;
            r_fail_num  <= '0;
            r_done      <= 1'b0;
            r_passed    <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_settle    <= w_settle_next;
            r_fail_num  <= w_fail_num_next;
            r_done      <= (w_state_next == ST_PASS) || (w_state_next == ST_FAIL) ||
                           (w_state_next == ST_TOUT);
            r_passed    <= (w_state_next == ST_PASS);
            r_timed_out <= (w_state_next == ST_TOUT);
        end
    end

    // Counters restart on entry to RUN and freeze on the edge that enters a verdict.
    assign w_cnt_clear = mon.clear || ((r_state == ST_IDLE) && mon.start);
    assign w_cnt_en    = is_active(r_state) && is_active(w_state_next);

    mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_count (w_cycle_count)
    );

`ifdef RISCV_TEST_MONITOR_INSTRET_EN
    mon_sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en && mon.pc_valid),
        .o_count (mon.instret_count)
    );
`endif

    assign mon.done        = r_done;
    assign mon.passed      = r_passed;
    assign mon.timed_out   = r_timed_out;
    assign mon.fail_num    = r_fail_num;
    assign mon.cycle_count = w_cycle_count;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: directed and random test programs against a trace-level model.
module tb_riscv_test_monitor;

    localparam int          XLEN    = 32;
    localparam int          CNT_W   = 32;
    localparam int          SETTLE  = 4;
    localparam int          TIMEOUT = 20;
    localparam logic [31:0] END_PC  = 32'h44;

    typedef struct {
        logic        passed;
        logic        timed_out;
        logic [30:0] fail_num;
        int unsigned cycles;
        int unsigned instret;
        int unsigned at_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_test_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) mon();

    riscv_test_monitor #(
        .XLEN(XLEN), .END_PC(END_PC), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    exp_t        sb_q[$];
    logic        prev_done = 1'b0;

    // Per-cycle program trace, index = RUN cycle number after start.
    bit          st_v [TIMEOUT];
    logic [31:0] st_pc[TIMEOUT];
    logic [31:0] st_gp[TIMEOUT];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_done"},      mon.done,        1'b0);
        check({name, "_passed"},    mon.passed,      1'b0);
        check({name, "_timed_out"}, mon.timed_out,   1'b0);
        check({name, "_fail_num"},  mon.fail_num,    '0);
        check({name, "_cycles"},    mon.cycle_count, '0);
`ifdef RISCV_TEST_MONITOR_INSTRET_EN
        check({name, "_instret"},   mon.instret_count, '0);
`endif
    endtask

    // Reference: scan the trace for the first run of SETTLE valid END_PC fetches
    // (bubbles ignored, any other valid PC restarts the run); otherwise time out.
    task automatic predict(output int n, output exp_t e);
        int hits;
        hits        = 0;
        n           = TIMEOUT - 1;
        e.passed    = 1'b0;
        e.timed_out = 1'b1;
        e.fail_num  = '0;
        for (int j = 0; j < TIMEOUT; j++) begin
            if (st_v[j] && st_pc[j] == END_PC) hits++;
            else if (st_v[j]) hits = 0;
            if (hits == SETTLE) begin
                n           = j;
                e.timed_out = 1'b0;
                e.passed    = (st_gp[j] == 32'd1);
                e.fail_num  = e.passed ? 31'd0 : st_gp[j][31:1];
                break;
            end
        end
        e.cycles  = n;
        e.instret = 0;
        for (int j = 0; j < n; j++) if (st_v[j]) e.instret++;
        e.at_cyc  = 0;
    endtask

    // Monitor: every rising done pops the oldest expectation and compares it.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (mon.done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", mon.done, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("verdict_cycle", cyc,             e.at_cyc);
                    check("passed",        mon.passed,      e.passed);
                    check("timed_out",     mon.timed_out,   e.timed_out);
                    check("fail_num",      mon.fail_num,    e.fail_num);
                    check("cycle_count",   mon.cycle_count, e.cycles);
`ifdef RISCV_TEST_MONITOR_INSTRET_EN
                    check("instret_count", mon.instret_count, e.instret);
`endif
                end
            end
            prev_done = mon.done;
        end
    end

    task automatic drive_noise();
        mon.pc_valid = 1'($urandom_range(0, 1));
        mon.pc       = ($urandom_range(0, 1) != 0) ? END_PC : $urandom;
        mon.gp       = $urandom;
        mon.start    = 1'($urandom_range(0, 1));
        mon.clear    = 1'b0;
    endtask

    task automatic fill_base();
        for (int j = 0; j < TIMEOUT; j++) begin
            st_v[j]  = 1'b1;
            st_pc[j] = 32'h100 + 32'(4 * j);
            st_gp[j] = $urandom;
        end
    endtask

    task automatic fill_random();
        int bias, r;
        bias = $urandom_range(2, 7);
        for (int j = 0; j < TIMEOUT; j++) begin
            st_v[j] = ($urandom_range(0, 3) != 0);
            r       = $urandom_range(0, 7);
            st_pc[j] = (r < bias) ? END_PC : ((r == 7) ? ($urandom & ~32'h3) : 32'h48);
            case ($urandom_range(0, 3))
                0:       st_gp[j] = 32'd1;
                1:       st_gp[j] = 32'd0;
                2:       st_gp[j] = $urandom_range(2, 15);
                default: st_gp[j] = $urandom;
            endcase
        end
    endtask

    // abort_at < 0: full test to verdict; otherwise rst is pulsed after that RUN cycle.
    task automatic run_test(input int abort_at);
        int   n, last;
        exp_t e;
        predict(n, e);
        @(posedge clk); #1;
        mon.start = 1'b1; mon.clear = 1'b0; mon.pc_valid = 1'b0;
        e.at_cyc = cyc + 2 + n;
        if (abort_at < 0) sb_q.push_back(e);
        last = (abort_at < 0) ? n : abort_at;
        for (int j = 0; j <= last; j++) begin
            @(posedge clk); #1;
            mon.pc_valid = st_v[j];
            mon.pc       = st_pc[j];
            mon.gp       = st_gp[j];
            mon.start    = 1'($urandom_range(0, 1));
        end
        if (abort_at >= 0) begin
            #2 rst = 1'b1;
            #1 check_idle("rst_async");
            @(posedge clk); #1;
            rst = 1'b0; mon.clear = 1'b1; mon.start = 1'b1;
            @(posedge clk); #1;
            mon.clear = 1'b0; mon.start = 1'b0;
            @(negedge clk) check_idle("rst_clear_start");
            @(negedge clk) check_idle("rst_idle_hold");
            return;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive_noise();
        end
        @(negedge clk);
        check("sb_drained",    sb_q.size(),     0);
        sb_q.delete();
        check("sticky_done",   mon.done,        1'b1);
        check("sticky_passed", mon.passed,      e.passed);
        check("sticky_tout",   mon.timed_out,   e.timed_out);
        check("sticky_fail",   mon.fail_num,    e.fail_num);
        check("sticky_cycles", mon.cycle_count, e.cycles);
        @(posedge clk); #1;
        mon.clear = 1'b1; mon.start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        mon.clear = 1'b0; mon.start = 1'b0;
        @(negedge clk) check_idle("clear");
        @(negedge clk) check_idle("clear_idle_hold");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mon.start = 1'b0; mon.clear = 1'b0; mon.pc_valid = 1'b0; mon.pc = '0; mon.gp = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        rst = 1'b0;
        @(negedge clk) check_idle("post_reset");

        // Four settle hits from the first cycle, gp = 1 -> pass.
        fill_base();
        for (int j = 0; j < 4; j++) st_pc[j] = END_PC;
        st_gp[3] = 32'd1;
        run_test(-1);

        // Broken settle run, then four hits with gp = 7 -> fail number 3.
        fill_base();
        st_pc[0] = END_PC; st_pc[1] = END_PC; st_pc[2] = 32'h48;
        for (int j = 3; j < 7; j++) st_pc[j] = END_PC;
        st_gp[6] = 32'd7;
        run_test(-1);

        // Never reaches END_PC -> timeout with cycle_count frozen at TIMEOUT-1.
        fill_base();
        run_test(-1);

        // Settle completes exactly in the limit cycle -> pass wins over timeout.
        fill_base();
        for (int j = TIMEOUT - 4; j < TIMEOUT; j++) st_pc[j] = END_PC;
        st_gp[TIMEOUT-1] = 32'd1;
        run_test(-1);

        // Bubble inside settle holds the count; gp = 0 -> fail number 0.
        fill_base();
        st_pc[2] = END_PC; st_v[3] = 1'b0; st_pc[3] = 32'h48;
        for (int j = 4; j < 7; j++) st_pc[j] = END_PC;
        st_gp[6] = 32'd0;
        run_test(-1);

        // Bubbles while running only stop instret.
        fill_base();
        st_v[2] = 1'b0; st_v[5] = 1'b0; st_v[8] = 1'b0;
        for (int j = 10; j < 14; j++) st_pc[j] = END_PC;
        st_gp[13] = 32'd1;
        run_test(-1);

        // Reset pulse in the middle of a settle run.
        fill_base();
        st_pc[0] = END_PC; st_pc[1] = END_PC;
        run_test(1);

        for (int t = 0; t < 40; t++) begin
            fill_random();
            run_test(-1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 Parameter XLEN, 32, width of the PC and GP operands.
REQ-002 Parameter END_PC, 32'h44, PC of the test-end loop.
REQ-003 Parameter SETTLE, 4, consecutive END_PC cycles required before GP is sampled (range 1..255).
REQ-004 Parameter TIMEOUT, 5000, cycle limit in RUN (range 1..2^CNT_W-1).
REQ-005 Parameter CNT_W, 32, cycle-counter width.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins monitoring.
REQ-009 clear  input  1  synchronous return to IDLE.
REQ-010 pc  input  XLEN  current core PC.
REQ-011 pc_valid  input  1  pc is meaningful this cycle (not a bubble or stall).
REQ-012 gp  input  XLEN  core register x3.
REQ-013 done  output  1  a verdict is held.
REQ-014 passed  output  1  the verdict is pass.
REQ-015 timed_out  output  1  the verdict is timeout.
REQ-016 fail_num  output  XLEN-1  failing test number, gp[XLEN-1:1].
REQ-017 cycle_count  output  CNT_W  cycles spent in RUN.

Function
REQ-018 The FSM states are IDLE, RUN, SETTLE, PASS, FAIL and TOUT.
REQ-019 IDLE goes to RUN on start; cycle_count clears to 0 on entry to RUN.
REQ-020 In RUN or SETTLE, cycle_count increments by 1 per cycle and saturates at all-ones.
REQ-021 RUN goes to SETTLE when pc_valid && pc==END_PC; the settle counter loads 1.
REQ-022 In SETTLE, each pc_valid && pc==END_PC cycle increments the settle counter, and a cycle with !pc_valid holds it.
REQ-023 In SETTLE, pc_valid && pc!=END_PC returns the FSM to RUN and zeroes the settle counter.
REQ-024 When the settle counter reaches SETTLE, gp is sampled that same cycle.
REQ-025 The sample gives PASS if gp==1; otherwise it gives FAIL with fail_num=gp[XLEN-1:1].
REQ-026 gp==0 at sample gives FAIL with fail_num=0.
REQ-027 RUN or SETTLE goes to TOUT when cycle_count==TIMEOUT-1 and no verdict is produced that cycle.
REQ-028 If the settle completion and the timeout limit occur in the same cycle, PASS or FAIL wins.
REQ-029 PASS, FAIL and TOUT are sticky; start is ignored in these states and in RUN or SETTLE.
REQ-030 clear moves any state to IDLE the next edge and zeroes all outputs; clear outranks start and all transitions.
REQ-031 done=1 in PASS, FAIL and TOUT; passed=1 only in PASS; timed_out=1 only in TOUT.
REQ-032 All outputs are registered, so a verdict is visible one cycle after its sampling edge.
REQ-033 fail_num and cycle_count freeze on entry to any verdict state.

Reset
REQ-034 rst asserted forces IDLE immediately, independent of clk.
REQ-035 During rst, done, passed, timed_out, fail_num, cycle_count and the settle counter are all 0.
REQ-036 rst asserted mid-test discards any partial settle count and any verdict.
REQ-037 After rst deasserts, the block waits in IDLE for start.

Configuration
REQ-038 With RISCV_TEST_MONITOR_INSTRET_EN defined, output instret_count [CNT_W-1:0] counts pc_valid cycles in RUN or SETTLE.
REQ-039 instret_count resets and clears with cycle_count, saturates at all-ones, and freezes at a verdict.
REQ-040 Without RISCV_TEST_MONITOR_INSTRET_EN, the instret_count port and its logic do not exist, and all other behaviour is identical.

Structure
REQ-041 Package riscv_test_pkg holds the FSM state encoding, the PASS_CODE constant (1), and the default END_PC and TIMEOUT values.
REQ-042 Sub-module mon_sat_counter is a parametrised-width saturating counter with clear and enable, instantiated for cycle_count and instret_count.
REQ-043 The settle counter is local to riscv_test_monitor.

Verification
REQ-044 Scenario: start; pc reaches 0x44 with valid for 4 cycles, gp=1 -> done=1, passed=1, fail_num=0 one cycle after the 4th cycle.
REQ-045 Scenario: pc=0x44 for 2 cycles, then 0x48, then 0x44 for 4 cycles, gp=0x7 -> FAIL with fail_num=3, and no early verdict.
REQ-046 Scenario: TIMEOUT=20, pc never reaches 0x44 -> timed_out=1 and cycle_count=19 (frozen) at cycle 20 after start.
REQ-047 Scenario: TIMEOUT=10, settle completes on the 10th RUN cycle -> passed=1 and timed_out=0.
REQ-048 Scenario: rst pulse mid-SETTLE, then clear and start issued in the same cycle -> all outputs 0 and the FSM stays in IDLE.
REQ-049 Scenario: with RISCV_TEST_MONITOR_INSTRET_EN, pc_valid low on 3 of 10 RUN cycles -> instret_count=7 while cycle_count=10.
